// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among num_req byte sources, with
// optional per-requester burst lock bounded by max_burst consecutive grants.
module uart_tx_arbiter #(
  parameter int unsigned num_req   = 4,
  parameter int unsigned data_bits = 8,
  parameter int unsigned max_burst = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_req-1:0]             req,
  input  logic [num_req-1:0]             lock,
  input  logic [num_req*data_bits-1:0]   req_data,
  output logic [num_req-1:0]             ack,
  output logic [((num_req > 1) ? $clog2(num_req) : 1)-1:0] grant_id,
  output logic                           busy,
  output logic                           tx_start,
  output logic [data_bits-1:0]           tx_din,
  input  logic                           tx_done_tick
);

  localparam int unsigned GW = (num_req > 1) ? $clog2(num_req) : 1;
  localparam int unsigned BW = (max_burst > 1) ? $clog2(max_burst) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

  state_t                 state_q, state_d;
  logic [num_req-1:0]     ack_q, ack_d;
  logic                   tx_start_q, tx_start_d;
  logic [data_bits-1:0]   tx_din_q, tx_din_d;
  logic [GW-1:0]          grant_id_q, grant_id_d;
  logic                   busy_q, busy_d;
  logic [GW-1:0]          rr_q, rr_d;
  logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
  logic                   locked_q, locked_d;

  logic [GW-1:0]          rr_win;
  logic                   rr_found;
  logic [31:0]            idx;
  logic [GW-1:0]          win;
  logic                   win_vld;

  // First requester at or after the rr pointer, wrapping at num_req.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < num_req; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= num_req) idx = idx - num_req;
      if (!rr_found && req[idx[GW-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = '0;
    tx_start_d  = 1'b0;
    tx_din_d    = tx_din_q;
    grant_id_d  = grant_id_q;
    busy_d      = 1'b0;
    rr_d        = rr_q;
    burst_cnt_d = burst_cnt_q;
    locked_d    = locked_q;
    win         = rr_win;
    win_vld     = rr_found;

    case (state_q)
      IDLE: begin
        if (locked_q && req[grant_id_q]) begin
          win     = grant_id_q;
          win_vld = 1'b1;
        end else if (locked_q) begin
          locked_d    = 1'b0;
          burst_cnt_d = '0;
        end
        if (win_vld) begin
          tx_din_d   = req_data[32'(win)*data_bits +: data_bits];
          grant_id_d = win;
          state_d    = START;
        end
      end
      START: state_d = WAIT;
      WAIT:  if (tx_done_tick) state_d = ACK;
      ACK: begin
        state_d = IDLE;
        if (lock[grant_id_q] && (32'(burst_cnt_q) < max_burst - 1)) begin
          locked_d    = 1'b1;
          burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
          locked_d    = 1'b0;
          burst_cnt_d = '0;
          if (32'(grant_id_q) == num_req - 1) rr_d = '0;
          else                                rr_d = grant_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it once registered.
    tx_start_d = (state_d == START);
    busy_d     = (state_d != IDLE);
    if (state_d == ACK) ack_d[grant_id_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ack_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_din_q    <= '0;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
      rr_q        <= '0;
      burst_cnt_q <= '0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      tx_start_q  <= tx_start_d;
      tx_din_q    <= tx_din_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
      rr_q        <= rr_d;
      burst_cnt_q <= burst_cnt_d;
      locked_q    <= locked_d;
    end
  end

  assign ack      = ack_q;
  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter between num_req independent byte sources using a round-robin scheme.
- Latches the winning requester's byte and drives the transmitter's tx_start/tx_din.
- Waits for tx_done_tick, then returns a one-cycle ack to the winner.
- Optional per-requester lock allows multi-byte bursts of up to max_burst bytes, after which rotation is forced.
- Sits between client logic and uart_tx; the baud tick path is untouched.

Parameters:
num_req, 4, number of requesters (2..16)
data_bits, 8, byte width; matches uart_tx
max_burst, 16, maximum consecutive grants to one locked requester (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  num_req  per-requester transmit request; level, held until ack
lock  input  num_req  per-requester burst hold; sampled at ack
req_data  input  num_req*data_bits  packed bytes; requester i at [i*data_bits +: data_bits]
ack  output  num_req  one-hot, one-cycle pulse: granted byte fully transmitted
grant_id  output  max(1,$clog2(num_req))  index of current/last granted requester
busy  output  1  high whenever state != IDLE
tx_start  output  1  one-cycle start pulse to uart_tx
tx_din  output  data_bits  byte to uart_tx; stable from tx_start until tx_done_tick
tx_done_tick  input  1  one-cycle completion pulse from uart_tx

Behaviour:
- Reset values: state=IDLE; ack=0; tx_start=0; tx_din=0; grant_id=0; busy=0; rr pointer=0; burst_cnt=0; locked=0.
- Reset mid-operation aborts immediately. Any tx_done_tick is ignored until the next grant.
- All outputs are registered.

FSM (IDLE, START, WAIT, ACK):
- IDLE:
  - If locked=1 and req[grant_id]=1, the winner is grant_id.
  - Otherwise the winner is the first i with req[i]=1, searching from rr pointer upward with wrap (num_req-1 -> 0).
  - If a winner exists: latch tx_din <= req_data slice, grant_id <= winner, go to START.
  - If req=0: stay in IDLE. If locked=1 but the owner dropped req, clear locked and arbitrate normally in the same cycle.
- START: tx_start=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Hold tx_din and grant_id.
  - On tx_done_tick go to ACK. No timeout.
  - tx_done_tick in IDLE, START or ACK is ignored.
- ACK: ack[grant_id]=1 for exactly this cycle, then go to IDLE. Lock and burst update:
  - If lock[grant_id]=1 and burst_cnt < max_burst-1: locked <= 1, burst_cnt <= burst_cnt+1, rr pointer unchanged.
  - Otherwise: locked <= 0, burst_cnt <= 0, rr pointer <= grant_id+1 mod num_req.
- Latency:
  - req first seen high in IDLE at cycle 0 -> tx_start high at cycle 1.
  - tx_done_tick at cycle k -> ack at k+1 -> IDLE at k+2 -> next tx_start at k+3 at the earliest.

Boundary conditions:
- Deasserting req after the grant does not cancel the transfer; ack is still issued.
- Changes to req_data after the grant do not affect tx_din.
- A requester must drop req the cycle after ack, or it will be considered again.
- Simultaneous requests are resolved purely by the rr pointer. Starvation is bounded by (num_req-1)*max_burst bytes.
- num_req=1 degenerates to a single-channel sequencer; grant_id is stuck at 0.

Test Plan:
- Single requester: reset, then req=0010 with slice1=0x5A -> next cycle tx_start=1 for 1 cycle, tx_din=0x5A, grant_id=1, busy=1. tx_done_tick pulse -> ack=0010 one cycle later, then busy=0.
- Fairness: req=1111 held, each acked req re-raised immediately, bytes 0xA0..0xA3 -> grant order 0,1,2,3,0,1. Exactly one ack bit per completion.
- Burst lock: max_burst=4, req=1100, lock[2]=1 -> four consecutive grants to 2, then grant to 3, then back to 2.
- Stability: change slice0 from 0x11 to 0xFF one cycle after tx_start while in WAIT -> tx_din stays 0x11 until ack. Stray tx_done_tick while IDLE -> no ack, no state change.
- Request withdrawal: req[3] dropped during WAIT -> ack[3] still pulses on completion. A locked owner dropping req -> next IDLE grants another requester.
- Reset mid-WAIT: assert reset for 1 cycle -> all outputs 0 next cycle. Following req=1001 -> grant_id=0 first (pointer reset).
